// File: rtl/seq_store.sv
// seq_store: result store with count-derived EMPTY/FILLING/FULL state and a wrapping display pointer
// Ports:
//   clk, reset (async, active-high), clr (sync clear pulse)
//   wr_valid/wr_err/wr_data : upstream result; stored only when wr_err == 0 and not full
//   nxt                     : advance the display pointer, wrapping at count
//   rd_data/rd_idx          : entry under the display pointer (0 when empty) and the pointer itself
//   count/full/empty        : number of valid entries and its flags
//   err_out/ovf/wr_ack      : sticky error code, sticky overflow, pulse after an accepted write
module seq_store #(
  parameter int DEPTH = 10,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             wr_valid,
  input  logic [1:0]       wr_err,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             nxt,
  output logic [WIDTH-1:0] rd_data,
  output logic [3:0]       rd_idx,
  output logic [3:0]       count,
  output logic             full,
  output logic             empty,
  output logic [1:0]       err_out,
  output logic             ovf,
  output logic             wr_ack
);
  localparam logic [3:0] LAST = 4'(DEPTH);
  typedef enum logic [1:0] {EMPTY, FILLING, FULL} state_t;
  state_t state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic accept;
  logic [3:0] idx_inc;
  // State is a pure function of count so the two can never disagree.
  always_comb begin
    state   = count == 4'd0 ? EMPTY : (count == LAST ? FULL : FILLING);
    accept  = wr_valid && wr_err == 2'd0 && state != FULL;
    idx_inc = rd_idx + 4'd1;
  end
  assign empty   = state == EMPTY;
  assign full    = state == FULL;
  assign rd_data = empty ? '0 : mem[rd_idx];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      rd_idx  <= '0;
      err_out <= '0;
      ovf     <= 1'b0;
      wr_ack  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      count   <= '0;
      rd_idx  <= '0;
      err_out <= '0;
      ovf     <= 1'b0;
      wr_ack  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      wr_ack <= accept;
      if (accept) begin
        mem[count] <= wr_data;
        count      <= count + 4'd1;
      end
      if (wr_valid && wr_err != 2'd0) err_out <= wr_err;
      if (wr_valid && wr_err == 2'd0 && state == FULL) ovf <= 1'b1;
      // Wrap compares against the pre-write count, so a same-cycle write does not extend the lap.
      if (nxt && !empty) rd_idx <= idx_inc == count ? 4'd0 : idx_inc;
    end
  end
endmodule

// File: tb/tb_seq_store.sv
// tb_seq_store: directed-vector self-checking bench for seq_store
module tb_seq_store;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clr = 1'b0;
  logic        wr_valid = 1'b0;
  logic [1:0]  wr_err = 2'd0;
  logic [31:0] wr_data = '0;
  logic        nxt = 1'b0;
  logic [31:0] rd_data;
  logic [3:0]  rd_idx;
  logic [3:0]  count;
  logic        full;
  logic        empty;
  logic [1:0]  err_out;
  logic        ovf;
  logic        wr_ack;
  int tests = 0;
  int fails = 0;

  seq_store dut (
    .clk(clk), .reset(reset), .clr(clr), .wr_valid(wr_valid), .wr_err(wr_err),
    .wr_data(wr_data), .nxt(nxt), .rd_data(rd_data), .rd_idx(rd_idx), .count(count),
    .full(full), .empty(empty), .err_out(err_out), .ovf(ovf), .wr_ack(wr_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] e, input logic [31:0] d, input logic n);
    wr_valid = 1'b1;
    wr_err = e;
    wr_data = d;
    nxt = n;
    tick();
    wr_valid = 1'b0;
    wr_err = 2'd0;
    wr_data = '0;
    nxt = 1'b0;
  endtask

  task automatic step_nxt();
    nxt = 1'b1;
    tick();
    nxt = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    tick();
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_err", 32'(err_out), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_ack", 32'(wr_ack), 0);
    reset = 1'b0;

    wr(2'd0, 32'h0000_1234, 1'b0);
    check("w1_count", 32'(count), 1);
    check("w1_rd_data", rd_data, 32'h0000_1234);
    check("w1_empty", 32'(empty), 0);
    check("w1_ack", 32'(wr_ack), 1);
    tick();
    check("w1_ack_drop", 32'(wr_ack), 0);

    wr(2'b10, 32'hFFFF_FFFF, 1'b0);
    check("err_count", 32'(count), 1);
    check("err_code", 32'(err_out), 2);
    check("err_rd_data", rd_data, 32'h0000_1234);
    check("err_ack", 32'(wr_ack), 0);

    wr_err = 2'b01;
    wr_data = 32'h5555;
    tick();
    wr_err = 2'd0;
    wr_data = '0;
    check("novalid_count", 32'(count), 1);
    check("novalid_err", 32'(err_out), 2);

    do_clr();
    check("clr_count", 32'(count), 0);
    check("clr_err", 32'(err_out), 0);
    check("clr_rd_data", rd_data, 0);

    for (int i = 1; i <= 10; i++) wr(2'd0, 32'(i), 1'b0);
    check("fill_count", 32'(count), 10);
    check("fill_full", 32'(full), 1);
    check("fill_ovf", 32'(ovf), 0);
    wr(2'd0, 32'd11, 1'b0);
    check("ovf_count", 32'(count), 10);
    check("ovf_flag", 32'(ovf), 1);
    check("ovf_no_ack", 32'(wr_ack), 0);
    for (int i = 0; i < 9; i++) step_nxt();
    check("last_idx", 32'(rd_idx), 9);
    check("last_data", rd_data, 10);
    step_nxt();
    check("full_wrap_idx", 32'(rd_idx), 0);
    check("full_wrap_data", rd_data, 1);

    do_clr();
    check("clr2_ovf", 32'(ovf), 0);
    wr(2'd0, 32'd0, 1'b0);
    check("zero_count", 32'(count), 1);
    check("zero_empty", 32'(empty), 0);
    check("zero_ack", 32'(wr_ack), 1);
    wr(2'd0, 32'd5, 1'b0);
    wr(2'd0, 32'd7, 1'b0);
    step_nxt();
    check("n1_idx", 32'(rd_idx), 1);
    check("n1_data", rd_data, 5);
    step_nxt();
    check("n2_idx", 32'(rd_idx), 2);
    check("n2_data", rd_data, 7);
    step_nxt();
    check("n3_idx", 32'(rd_idx), 0);
    check("n3_data", rd_data, 0);
    step_nxt();
    check("n4_idx", 32'(rd_idx), 1);

    wr(2'd0, 32'd9, 1'b1);
    check("sim1_idx", 32'(rd_idx), 2);
    check("sim1_count", 32'(count), 4);
    step_nxt();
    check("pre_wrap_idx", 32'(rd_idx), 3);
    check("pre_wrap_data", rd_data, 9);
    wr(2'd0, 32'h44, 1'b1);
    check("sim2_idx", 32'(rd_idx), 0);
    check("sim2_count", 32'(count), 5);

    wr(2'b01, 32'h1, 1'b0);
    check("e1_code", 32'(err_out), 1);
    check("e1_count", 32'(count), 5);
    clr = 1'b1;
    wr(2'd0, 32'hABCD, 1'b1);
    clr = 1'b0;
    check("clrwr_count", 32'(count), 0);
    check("clrwr_idx", 32'(rd_idx), 0);
    check("clrwr_err", 32'(err_out), 0);
    check("clrwr_data", rd_data, 0);
    check("clrwr_ack", 32'(wr_ack), 0);

    for (int i = 0; i < 4; i++) wr(2'd0, 32'(i + 100), 1'b0);
    step_nxt();
    check("pre_async_count", 32'(count), 4);
    check("pre_async_ack", 32'(wr_ack), 0);
    #2;
    reset = 1'b1;
    #1;
    check("async_count", 32'(count), 0);
    check("async_idx", 32'(rd_idx), 0);
    check("async_data", rd_data, 0);
    check("async_empty", 32'(empty), 1);
    #1;
    reset = 1'b0;
    wr(2'd0, 32'hBEEF, 1'b0);
    check("first_edge_count", 32'(count), 1);
    check("first_edge_data", rd_data, 32'hBEEF);

    reset = 1'b1;
    wr(2'd0, 32'h77, 1'b1);
    check("rst_op_count", 32'(count), 0);
    check("rst_op_ack", 32'(wr_ack), 0);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
